inst_loader: RTL

Program loader: the write-side counterpart of the instruction ROM. It accepts a byte stream over a valid/ready handshake and parses a 16-bit word-count header. It assembles the following bytes into 32-bit instructions and writes them into the instruction memory at consecutive word-aligned byte addresses. It holds the processor (`cpu_hold`) for the duration of the load.

---
 rtl/inst_loader_pkg.sv | 22 ++
 rtl/word_assembler.sv | 38 +++
 rtl/inst_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the program loader: FSM encodings, stream framing
// constants and the byte-flip used by the instruction ROM read path.
package inst_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR_HI = 3'd1;
  localparam state_t ST_HDR_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERR    = 3'd6;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic [31:0] flip_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one word (first byte ends up in [31:24])
// and pulses word_valid for the cycle after the fourth byte is taken.
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte,
  output logic        word_valid
);

  logic [1:0] count;

  assign last_byte = (count == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift && last_byte;
      if (shift) begin
        word  <= {word[23:0], byte_in};
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Program loader: parses a 16-bit word-count header from a byte stream and
// writes the following words to instruction memory while holding the CPU.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter bit FLIP_INS_BIT = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  state_t                state;
  state_t                next_state;
  logic [7:0]            hdr_hi;
  logic [15:0]           word_count;
  logic [ADDR_WIDTH:0]   index;
  logic [ADDR_WIDTH:0]   index_next;
  logic [15:0]           hdr_n;
  logic                  xfer;
  logic                  start_load;
  logic                  last_byte;
  logic [31:0]           word;

  assign xfer       = rx_valid && rx_ready;
  assign hdr_n      = {hdr_hi, rx_data};
  assign index_next = index + 1'b1;
  assign start_load = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  word_assembler u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start_load),
    .shift      (xfer && state == ST_DATA),
    .byte_in    (rx_data),
    .word       (word),
    .last_byte  (last_byte),
    .word_valid (wr_en)
  );

  // Assembled word is a register, so the flip below is pure wiring.
  assign wr_data  = FLIP_INS_BIT ? flip_bytes(word) : word;
  assign wr_addr  = {{(32 - ADDR_WIDTH - 3){1'b0}}, index, 2'b00};
  assign cpu_hold = busy;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_HDR_HI;
      ST_HDR_HI: if (xfer) next_state = ST_HDR_LO;
      ST_HDR_LO: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                next_state = ST_DONE;
          else if ({1'b0, hdr_n} > CAPACITY) next_state = ST_ERR;
          else                               next_state = ST_DATA;
        end
      end
      ST_DATA: if (xfer && last_byte) next_state = ST_WRITE;
      ST_WRITE: begin
        if (17'(index_next) == {1'b0, word_count}) next_state = ST_DONE;
        else                                       next_state = ST_DATA;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hdr_hi     <= '0;
      word_count <= '0;
      index      <= '0;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= next_state;
      rx_ready <= (next_state == ST_HDR_HI) || (next_state == ST_HDR_LO) ||
                  (next_state == ST_DATA);
      busy     <= (next_state == ST_HDR_HI) || (next_state == ST_HDR_LO) ||
                  (next_state == ST_DATA)   || (next_state == ST_WRITE);
      done     <= (next_state == ST_DONE);
      error    <= (next_state == ST_ERR);
      if (start_load)                  index      <= '0;
      if (state == ST_HDR_HI && xfer)  hdr_hi     <= rx_data;
      if (state == ST_HDR_LO && xfer)  word_count <= hdr_n;
      if (state == ST_WRITE)           index      <= index_next;
    end
  end

endmodule
